// File: rtl/bcd_digit_mult_seq.sv
// bcd_digit_mult_seq
//   Multiplies an NDIG-digit BCD operand by a single BCD digit by
//   time-sharing one external combinational 1x1-digit BCD multiplier,
//   one operand digit per cycle, and rippling the BCD carry upward.
//   The product has NDIG+1 BCD digits.
//
//   Optional feature macro: BCD_INPUT_CHECK_EN
//     When defined, the operands are checked for non-BCD digits at start.
//     An invalid operand skips the multiply, and returns p_bcd=0 with err=1.
//     When undefined, err is always 0 and invalid digits pass straight
//     through to the multiplier.
//
//   Handshake: start is a request sampled only while idle; a request seen
//   in any other state is dropped, not queued. done is a registered
//   one-cycle pulse. err is valid only while done is high. p_bcd holds the
//   last result until the next done pulse.
//
//   Timing: start is sampled at edge k. done is high in the cycle after
//   edge k+NDIG+1. A new start can be sampled at edge k+NDIG+2.
module bcd_digit_mult_seq #(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*NDIG-1:0]       a_bcd,
    input  logic [3:0]              b_bcd,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [4*(NDIG+1)-1:0]   p_bcd,
    output logic [3:0]              mul_x1,
    output logic [3:0]              mul_x2,
    input  logic [7:0]              mul_y,
    output logic [1:0]              dbg_state
);

`ifdef BCD_INPUT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int PW   = 4 * (NDIG + 1);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [3:0]          carry_q, carry_d;
    logic [4*NDIG-1:0]   a_q, a_d;
    logic [3:0]          b_q, b_d;
    logic [PW-1:0]       res_q, res_d;
    logic [PW-1:0]       p_q, p_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                errp_q, errp_d;

    // Datapath scratch values used while a digit is processed.
    logic [3:0]          a_dig;
    logic [4:0]          sum;
    logic [4:0]          sum_m10;
    logic [3:0]          dig;
    logic [3:0]          cnext;

    // Returns 1 when every digit of a and b lies in the range 0..9.
    function automatic logic inputs_bcd(input logic [4*NDIG-1:0] a,
                                        input logic [3:0] b);
        logic ok;
        ok = (b <= 4'd9);
        for (int i = 0; i < NDIG; i++) begin
            if (a[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // State, operand, result and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            p_q     <= p_d;
            done_q  <= done_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
        end
    end

    // Next-state logic, one digit step per MUL cycle, multiplier operand
    // drive, and assembly of the result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        p_d     = p_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        errp_d  = errp_q;
        busy    = 1'b0;
        mul_x1  = 4'd0;
        mul_x2  = 4'd0;
        a_dig   = 4'd0;
        sum     = 5'd0;
        sum_m10 = 5'd0;
        dig     = 4'd0;
        cnext   = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_bcd;
                    b_d     = b_bcd;
                    idx_d   = '0;
                    carry_d = 4'd0;
                    res_d   = '0;
                    if (CHECK_EN && !inputs_bcd(a_bcd, b_bcd)) begin
                        errp_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        errp_d  = 1'b0;
                        state_d = S_MUL;
                    end
                end
            end

            S_MUL: begin
                busy = 1'b1;
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == i[IDXW-1:0]) a_dig = a_q[i*4 +: 4];
                end
                mul_x1 = a_dig;
                mul_x2 = b_q;

                // Add the incoming carry to the low product digit. The
                // carry is at most 9, because the high digit is at most 8.
                sum     = {1'b0, mul_y[3:0]} + {1'b0, carry_q};
                sum_m10 = sum - 5'd10;
                if (sum > 5'd9) begin
                    dig   = sum_m10[3:0];
                    cnext = mul_y[7:4] + 4'd1;
                end else begin
                    dig   = sum[3:0];
                    cnext = mul_y[7:4];
                end

                for (int i = 0; i < NDIG; i++) begin
                    if (idx_q == i[IDXW-1:0]) res_d[i*4 +: 4] = dig;
                end
                carry_d = cnext;

                if (idx_q == LAST_IDX) begin
                    res_d[4*NDIG +: 4] = cnext;
                    state_d            = S_FIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_FIN: begin
                p_d     = res_q;
                done_d  = 1'b1;
                err_d   = errp_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done      = done_q;
    assign err       = err_q;
    assign p_bcd     = p_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_digit_mult_seq.sv
// tb_bcd_digit_mult_seq
//   Directed vectors with hand-computed products. A driver issues the
//   operations and pushes the expected {err, p_bcd} into exp_q. A separate
//   monitor pops exp_q and compares whenever done is high.
module tb_bcd_digit_mult_seq;
    localparam int NDIG = 4;
    localparam int PW   = 4 * (NDIG + 1);
    localparam int W    = PW + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [4*NDIG-1:0]    a_bcd;
    logic [3:0]           b_bcd;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [PW-1:0]        p_bcd;
    logic [3:0]           mul_x1;
    logic [3:0]           mul_x2;
    logic [7:0]           mul_y;
    logic [1:0]           dbg_state;

    logic [W-1:0]         exp_q[$];
    logic [PW-1:0]        hold_p;
    int                   n_vec;
    int                   n_miss;

    bcd_digit_mult_seq #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .p_bcd     (p_bcd),
        .mul_x1    (mul_x1),
        .mul_x2    (mul_x2),
        .mul_y     (mul_y),
        .dbg_state (dbg_state)
    );

    // Shared external 1x1-digit BCD multiplier (combinational).
    function automatic logic [7:0] bcd_mul(input logic [3:0] x1, input logic [3:0] x2);
        int prod;
        prod = int'(x1) * int'(x2);
        return {4'(prod / 10), 4'(prod % 10)};
    endfunction

    always_comb mul_y = bcd_mul(mul_x1, mul_x2);

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Monitor: result check on done, hold/err-low check otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got p_bcd %h with empty queue", p_bcd);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("result", 32'({err, p_bcd}), 32'(e));
                    hold_p = e[PW-1:0];
                end
            end else begin
                chk("p_hold", 32'(p_bcd), 32'(hold_p));
                chk("err_idle", 32'(err), 32'd0);
            end
        end
    end

    // Issues one valid operation. Starts at the current negedge and returns
    // at the negedge where done must be high, so calls can run back-to-back.
    // ign_at >= 0 raises an extra start at that cycle, which must be dropped.
    task automatic run_op(input logic [4*NDIG-1:0] a, input logic [3:0] b,
                          input logic [PW-1:0] exp_p, input int ign_at);
        start = 1'b1;
        a_bcd = a;
        b_bcd = b;
        exp_q.push_back({1'b0, exp_p});
        for (int j = 0; j <= NDIG + 1; j++) begin
            @(negedge clk);
            if (j < NDIG) begin
                chk("busy", 32'(busy), 32'd1);
                chk("mul_x1", 32'(mul_x1), 32'(a[j*4 +: 4]));
                chk("mul_x2", 32'(mul_x2), 32'(b));
            end else if (j == NDIG) begin
                chk("fin_busy", 32'(busy), 32'd0);
                chk("fin_x1", 32'(mul_x1), 32'd0);
                chk("fin_done", 32'(done), 32'd0);
            end else begin
                chk("done_latency", 32'(done), 32'd1);
            end
            start = 1'b0;
            a_bcd = 16'($urandom);
            b_bcd = 4'($urandom_range(0, 9));
            if (j == ign_at) begin
                start = 1'b1;
                a_bcd = 16'h1111;
                b_bcd = 4'd2;
            end
        end
    endtask

`ifdef BCD_INPUT_CHECK_EN
    // Issues an operation with a non-BCD operand. It must bypass the
    // multiply, with done high one cycle after the start edge.
    task automatic run_bad(input logic [4*NDIG-1:0] a, input logic [3:0] b);
        start = 1'b1;
        a_bcd = a;
        b_bcd = b;
        exp_q.push_back({1'b1, {PW{1'b0}}});
        @(negedge clk);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_x1", 32'(mul_x1), 32'd0);
        chk("bad_done_early", 32'(done), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("bad_done", 32'(done), 32'd1);
    endtask
`endif

    // Reset block and directed sequence.
    initial begin
        n_vec  = 0;
        n_miss = 0;
        hold_p = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_bcd  = '0;
        b_bcd  = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_p", 32'(p_bcd), 32'd0);
        chk("rst_x1", 32'(mul_x1), 32'd0);
        chk("rst_x2", 32'(mul_x2), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 4'd5, 20'h06170, -1);
        run_op(16'h9999, 4'd9, 20'h89991, -1);
        run_op(16'h0407, 4'd0, 20'h00000, -1);
        run_op(16'h1234, 4'd5, 20'h06170, 1);
        run_op(16'h5555, 4'd2, 20'h11110, NDIG);
        run_op(16'h0000, 4'd7, 20'h00000, -1);
        run_op(16'h0999, 4'd9, 20'h08991, -1);
        run_op(16'h9876, 4'd3, 20'h29628, -1);
`ifdef BCD_INPUT_CHECK_EN
        run_bad(16'h12A4, 4'd3);
        run_bad(16'h0012, 4'hA);
        run_op(16'h0012, 4'd3, 20'h00036, -1);
`endif

        // Abort an operation at idx=2. Nothing is pushed, so any done
        // pulse from it is reported by the monitor.
        start = 1'b1;
        a_bcd = 16'h1234;
        b_bcd = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        hold_p = '0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_p", 32'(p_bcd), 32'd0);
        chk("abort_x1", 32'(mul_x1), 32'd0);
        chk("abort_x2", 32'(mul_x2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NDIG + 2) @(negedge clk);
        run_op(16'h0001, 4'd3, 20'h00003, -1);

        repeat (6) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
